// File: rtl/bus_fetch_initiator.sv
// Host-driven initiator for the 4-bit multiplexed instruction bus.
// Runs SYNC, A1-A3, M1/M2 and an optional X2 nibble transfer.
module bus_fetch_initiator #(
    parameter int ADDR_WIDTH  = 12,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [1:0]             req_mode,
    input  logic [3:0]             req_wdata,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   io_valid,
    output logic [3:0]             io_data,
    output logic                   sync,
    output logic [3:0]             data_out,
    output logic                   data_oe,
    input  logic [3:0]             data_in,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_M1,
        ST_M2,
        ST_X1,
        ST_X2,
        ST_X3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            mode_q;
    logic [3:0]            wdata_q;
    logic                  accept;
    logic                  mode_wr;
    logic                  mode_rd;

    assign accept  = req_valid & req_ready;
    assign mode_wr = (mode_q == 2'd1);
    assign mode_rd = (mode_q == 2'd2);

    // State register; reset abandons any cycle in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed walk through the phases, X3 may chain to A1
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_SYNC;
            ST_SYNC: state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_A3;
            ST_A3:   state_d = ST_M1;
            ST_M1:   state_d = ST_M2;
            ST_M2:   state_d = ST_X1;
            ST_X1:   state_d = ST_X2;
            ST_X2:   state_d = ST_X3;
            ST_X3:   state_d = accept ? ST_A1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state (sync also sees req_valid in X3)
    always_comb begin
        req_ready = 1'b0;
        sync      = 1'b0;
        data_oe   = 1'b0;
        data_out  = 4'h0;
        rsp_valid = 1'b0;
        io_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_SYNC: sync = 1'b1;
            ST_A1: begin
                data_oe  = 1'b1;
                data_out = addr_q[3:0];
            end
            ST_A2: begin
                data_oe  = 1'b1;
                data_out = addr_q[7:4];
            end
            ST_A3: begin
                data_oe  = 1'b1;
                data_out = addr_q[11:8];
            end
            ST_X1: rsp_valid = 1'b1;
            ST_X2: begin
                data_oe  = mode_wr;
                data_out = mode_wr ? wdata_q : 4'h0;
            end
            ST_X3: begin
                req_ready = 1'b1;
                sync      = req_valid;
                io_valid  = mode_rd;
            end
            default: ;
        endcase
    end

    // Request capture, bus sampling and completed-cycle counting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            mode_q      <= 2'd0;
            wdata_q     <= 4'h0;
            rsp_data    <= 8'h00;
            io_data     <= 4'h0;
            cycle_count <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                mode_q  <= req_mode;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_M1) rsp_data[7:4] <= data_in;
            if (state_q == ST_M2) rsp_data[3:0] <= data_in;
            if (state_q == ST_X2 && mode_rd) io_data <= data_in;
            if (state_q == ST_X3) cycle_count <= cycle_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_bus_fetch_initiator.sv
// Directed bench for bus_fetch_initiator.
// A second instance with COUNT_WIDTH=2 shares stimulus for the wrap test.
module tb_bus_fetch_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [11:0] req_addr;
    logic [1:0]  req_mode;
    logic [3:0]  req_wdata;
    logic [3:0]  data_in;

    logic        req_ready, rsp_valid, io_valid, sync, data_oe;
    logic [7:0]  rsp_data;
    logic [3:0]  io_data, data_out;
    logic [15:0] cycle_count;

    logic        r2_ready, r2_rsp_valid, r2_io_valid, r2_sync, r2_oe;
    logic [7:0]  r2_rsp_data;
    logic [3:0]  r2_io_data, r2_data_out;
    logic [1:0]  r2_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bus_fetch_initiator #(.ADDR_WIDTH(12), .COUNT_WIDTH(16)) dut (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mode(req_mode), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .io_valid(io_valid), .io_data(io_data),
        .sync(sync), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .cycle_count(cycle_count)
    );

    bus_fetch_initiator #(.ADDR_WIDTH(12), .COUNT_WIDTH(2)) dut2 (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(r2_ready),
        .req_addr(req_addr), .req_mode(req_mode), .req_wdata(req_wdata),
        .rsp_valid(r2_rsp_valid), .rsp_data(r2_rsp_data),
        .io_valid(r2_io_valid), .io_data(r2_io_data),
        .sync(r2_sync), .data_out(r2_data_out), .data_oe(r2_oe),
        .data_in(data_in), .cycle_count(r2_count)
    );

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 1'b0;
        data_in = 4'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // C0: present a request from IDLE; returns #1 into C0
    task automatic start_req(input logic [11:0] a, input logic [1:0] m,
                             input logic [3:0] w);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_mode  = m;
        req_wdata = w;
        data_in   = 4'h0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else passed++;
        total++; if (rsp_data !== 8'h00) $display("FAIL rst_rsp_data got %h want 00", rsp_data); else passed++;
        total++; if (cycle_count !== 16'd0) $display("FAIL rst_count got %0d want 0", cycle_count); else passed++;
        total++; if (io_data !== 4'h0) $display("FAIL rst_io_data got %h want 0", io_data); else passed++;
        start_req(12'hFFF, 2'd0, 4'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
        end
        total++; if (data_oe !== 1'b1) $display("FAIL a2_oe got %b want 1", data_oe); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (data_oe !== 1'b0) $display("FAIL midrst_oe got %b want 0", data_oe); else passed++;
        total++; if (sync !== 1'b0) $display("FAIL midrst_sync got %b want 0", sync); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else passed++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            total++; if (rsp_valid !== 1'b0) $display("FAIL midrst_rsp c%0d got %b want 0", c, rsp_valid); else passed++;
        end
        total++; if (cycle_count !== 16'd0) $display("FAIL midrst_count got %0d want 0", cycle_count); else passed++;
    endtask

    task automatic test_single_fetch;
        logic [11:0] a;
        logic [3:0]  en;
        a = 12'h3A5;
        start_req(a, 2'd0, 4'h0);
        total++; if (req_ready !== 1'b1) $display("FAIL sf_c0_ready got %b want 1", req_ready); else passed++;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            data_in = (c == 5) ? 4'hD : (c == 6) ? 4'h4 : 4'h0;
            #1;
            if (c == 1) begin
                total++; if (sync !== 1'b1) $display("FAIL sf_sync got %b want 1", sync); else passed++;
                total++; if (req_ready !== 1'b0) $display("FAIL sf_busy got %b want 0", req_ready); else passed++;
            end
            if (c >= 2 && c <= 4) begin
                en = a[(c-2)*4 +: 4];
                total++; if (data_out !== en || data_oe !== 1'b1)
                    $display("FAIL sf_addr c%0d got %h/%b want %h/1", c, data_out, data_oe, en); else passed++;
            end
            total++; if (rsp_valid !== (c == 7)) $display("FAIL sf_rsp_valid c%0d got %b", c, rsp_valid); else passed++;
            if (c == 7) begin
                total++; if (rsp_data !== 8'hD4) $display("FAIL sf_rsp_data got %h want d4", rsp_data); else passed++;
            end
            if (c == 10) begin
                total++; if (req_ready !== 1'b1 || sync !== 1'b0)
                    $display("FAIL sf_idle got ready %b sync %b want 1 0", req_ready, sync); else passed++;
                total++; if (cycle_count !== 16'd1) $display("FAIL sf_count got %0d want 1", cycle_count); else passed++;
            end
        end
    endtask

    task automatic test_x2_write;
        logic eo;
        start_req(12'h123, 2'd1, 4'h9);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            eo = (c >= 2 && c <= 4) || (c == 8);
            total++; if (data_oe !== eo) $display("FAIL wr_oe c%0d got %b want %b", c, data_oe, eo); else passed++;
            total++; if (io_valid !== 1'b0) $display("FAIL wr_io_valid c%0d got %b want 0", c, io_valid); else passed++;
            if (c == 8) begin
                total++; if (data_out !== 4'h9) $display("FAIL wr_data got %h want 9", data_out); else passed++;
            end
        end
        total++; if (cycle_count !== 16'd2) $display("FAIL wr_count got %0d want 2", cycle_count); else passed++;
    endtask

    task automatic test_x2_read;
        start_req(12'h456, 2'd2, 4'hF);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            data_in = (c == 8) ? 4'h6 : 4'h1;
            #1;
            total++; if (io_valid !== (c == 9)) $display("FAIL rd_io_valid c%0d got %b", c, io_valid); else passed++;
            if (c == 8) begin
                total++; if (data_oe !== 1'b0) $display("FAIL rd_x2_oe got %b want 0", data_oe); else passed++;
            end
            if (c == 9 || c == 10) begin
                total++; if (io_data !== 4'h6) $display("FAIL rd_io_data c%0d got %h want 6", c, io_data); else passed++;
            end
        end
        total++; if (rsp_data !== 8'h11) $display("FAIL rd_rsp_data got %h want 11", rsp_data); else passed++;
    endtask

    task automatic test_mode3;
        logic eo;
        start_req(12'h789, 2'd3, 4'hF);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            data_in = 4'hB;
            #1;
            eo = (c >= 2 && c <= 4);
            total++; if (data_oe !== eo) $display("FAIL m3_oe c%0d got %b want %b", c, data_oe, eo); else passed++;
            total++; if (io_valid !== 1'b0) $display("FAIL m3_io_valid c%0d got %b want 0", c, io_valid); else passed++;
        end
        total++; if (io_data !== 4'h6) $display("FAIL m3_io_hold got %h want 6", io_data); else passed++;
        total++; if (cycle_count !== 16'd4) $display("FAIL m3_count got %0d want 4", cycle_count); else passed++;
    endtask

    task automatic test_back_to_back;
        logic es;
        do_reset();
        start_req(12'h000, 2'd0, 4'h0);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            req_valid = (c <= 17);
            req_addr  = (c <= 8) ? 12'h000 : (c <= 16) ? 12'h001 : 12'h002;
            #1;
            es = (c == 1) || (c == 9) || (c == 17);
            total++; if (sync !== es) $display("FAIL b2b_sync c%0d got %b want %b", c, sync, es); else passed++;
            total++; if (rsp_valid !== (c == 7 || c == 15 || c == 23))
                $display("FAIL b2b_rsp_valid c%0d got %b", c, rsp_valid); else passed++;
            if (c == 10) begin
                total++; if (data_out !== 4'h1 || data_oe !== 1'b1)
                    $display("FAIL b2b_a1_second got %h/%b want 1/1", data_out, data_oe); else passed++;
            end
            if (c == 18) begin
                total++; if (data_out !== 4'h2 || data_oe !== 1'b1)
                    $display("FAIL b2b_a1_third got %h/%b want 2/1", data_out, data_oe); else passed++;
            end
        end
        total++; if (cycle_count !== 16'd3) $display("FAIL b2b_count got %0d want 3", cycle_count); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_counter_wrap;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            start_req(12'(k), 2'd0, 4'h0);
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                req_valid = 1'b0;
                #1;
            end
            total++; if (r2_count !== exp_cnt[k])
                $display("FAIL wrap_count k%0d got %0d want %0d", k, r2_count, exp_cnt[k]); else passed++;
        end
        total++; if (cycle_count !== 16'd5) $display("FAIL wrap_wide_count got %0d want 5", cycle_count); else passed++;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 12'h000;
        req_mode  = 2'd0;
        req_wdata = 4'h0;
        data_in   = 4'h0;
        test_reset();
        test_single_fetch();
        test_x2_write();
        test_x2_read();
        test_mode3();
        test_back_to_back();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_fetch_initiator.md
# bus_fetch_initiator

- Standalone initiator for the 4-bit multiplexed instruction bus.
- Produces the 8-phase instruction cycle on behalf of a host: SYNC marker, three address nibbles (A1–A3), opcode capture (M1/M2), then an optional single-nibble data transfer in X2.
- Used to exercise ROM and RAM responders directly, without the CPU, and as a bus driver for bring-up.
- Sits between a host-side request/response handshake and the shared `sync`/data bus.

## Interface

Parameters:
- `ADDR_WIDTH`, default 12: fetch address width. Must be 12 (three nibbles).
- `COUNT_WIDTH`, default 16: width of the completed-cycle counter.

Ports:
- `clock`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  host has a request.
- `req_ready`  output  1  block can accept a request this cycle.
- `req_addr`  input  12  fetch address.
- `req_mode`  input  2  X2 action: 0 none, 1 write, 2 read, 3 treated as 0.
- `req_wdata`  input  4  nibble driven in X2 when mode = 1.
- `rsp_valid`  output  1  one-cycle pulse; `rsp_data` is valid.
- `rsp_data`  output  8  fetched byte {M1 nibble, M2 nibble}.
- `io_valid`  output  1  one-cycle pulse; `io_data` is valid (mode 2 only).
- `io_data`  output  4  nibble sampled in X2.
- `sync`  output  1  cycle-start marker.
- `data_out`  output  4  bus drive value.
- `data_oe`  output  1  bus drive enable.
- `data_in`  input  4  bus sample value.
- `cycle_count`  output  COUNT_WIDTH  completed instruction cycles; wraps.

## Operation

- States: IDLE, SYNC, A1, A2, A3, M1, M2, X1, X2, X3.
- Request acceptance: a request is accepted on a rising edge when `req_valid & req_ready`.
  - Address, mode and wdata are captured into internal registers on acceptance.
  - Host inputs are ignored at all other times.
- `req_ready` = 1 in IDLE and X3 only.
- Transitions:
  - IDLE→SYNC on accept, else stay in IDLE.
  - SYNC→A1→A2→A3→M1→M2→X1→X2→X3, one state per clock.
  - X3→A1 on accept, else X3→IDLE.
- `sync`:
  - 1 in SYNC.
  - 1 in X3 when `req_valid` is high; this is combinational so back-to-back cycles need no SYNC state.
  - 0 otherwise.
- Bus drive, decoded from registered state:
  - A1: `data_oe`=1, `data_out`=addr[3:0].
  - A2: `data_oe`=1, `data_out`=addr[7:4].
  - A3: `data_oe`=1, `data_out`=addr[11:8].
  - X2 with mode 1: `data_oe`=1, `data_out`=wdata.
  - All other states: `data_oe`=0, `data_out`=0.
- Sampling:
  - End of M1: `data_in` → rsp_data[7:4].
  - End of M2: `data_in` → rsp_data[3:0].
  - End of X2, mode 2 only: `data_in` → io_data.
- Pulses:
  - `rsp_valid`=1 during X1.
  - `io_valid`=1 during X3, mode 2 only.
- `rsp_data` and `io_data` hold their values until overwritten by the next capture.
- `cycle_count` increments on leaving X3; wraps from all-ones to 0.
- Reset (`reset_n`=0, asynchronous):
  - State goes to IDLE; all outputs go to 0, including `rsp_data`, `io_data` and `cycle_count`.
  - Consequence: `req_ready`=1 immediately after reset, since the block is in IDLE.
  - Reset asserted mid-cycle abandons the cycle: no `rsp_valid` and no count increment.
  - `data_oe` drops without waiting for a clock edge.

## Timing

Let C0 be the accept cycle from IDLE.
- C1: SYNC.
- C2–C4: A1–A3.
- C5: M1.
- C6: M2.
- C7: X1, `rsp_valid`.
- C8: X2.
- C9: X3, `io_valid` if mode 2.
- Latency from accept to `rsp_valid` is 7 clocks from IDLE and 6 clocks from X3.
- Throughput: one instruction cycle per 8 clocks when requests are back-to-back (accepted in X3), 9 clocks from IDLE.
- Mode 3 behaves exactly as mode 0.
- An address wider than 12 bits is not supported.
- No combinational path from `data_in` to any output.

## Test plan

- Reset value: assert `reset_n`=0 mid-A2 → same cycle `data_oe`=0, `sync`=0, `req_ready`=1 after release, `cycle_count`=0, no `rsp_valid`.
- Single fetch: addr 0x3A5, mode 0, responder drives 0xD in M1 and 0x4 in M2:
  - `data_out` sequence is 5, A, 3 in C2–C4.
  - `rsp_valid` in C7 with `rsp_data`=0xD4.
  - IDLE at C10; `cycle_count`=1.
- X2 write: mode 1, wdata 0x9 → `data_oe`=1 with `data_out`=0x9 in X2 only; `io_valid` never asserts.
- X2 read: mode 2, bus 0x6 in X2 → `io_valid` in X3 with `io_data`=0x6.
- Back-to-back: `req_valid` held with addrs 0x000, 0x001, 0x002:
  - `sync` high in SYNC and in both X3s.
  - A1 follows X3 directly; `rsp_valid` pulses 8 clocks apart.
  - `cycle_count`=3.
- Counter wrap: COUNT_WIDTH=2, five cycles → `cycle_count` sequence 1, 2, 3, 0, 1.
